// File: rtl/mem_arb_pkg.sv
// Shared command encoding, FSM state type and request decode for the
// PS/PL memory port arbiter.
package mem_arb_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_IDLE  = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic is_active(input logic [2:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: bit 0 is the PS, bit 1 is the PL. On a tie the
// port that was not served last wins; the pointer lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_pl_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from the request vector and the last-served pointer
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_pl_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the PS bridge
// and the PL calculator; every access takes IDLE -> ACCESS -> RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        ps_cmd,
  input  logic [ADDR_W-1:0] ps_addr,
  input  logic [DATA_W-1:0] ps_wdata,
  output logic [DATA_W-1:0] ps_rdata,
  output logic              ps_ack,
  input  logic [2:0]        pl_cmd,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_wdata,
  output logic [DATA_W-1:0] pl_rdata,
  output logic              pl_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_pl,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                last_pl_q, last_pl_d;
  logic                wr_q, wr_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                grant_pl_q, grant_pl_d;
  logic                ps_ack_q, ps_ack_d;
  logic                pl_ack_q, pl_ack_d;
  logic [DATA_W-1:0]   ps_rdata_q, ps_rdata_d;
  logic [DATA_W-1:0]   pl_rdata_q, pl_rdata_d;
  logic [1:0]          req_s;
  logic [1:0]          gnt_s;
  logic [2:0]          win_cmd_s;

  // A port whose ack is high this cycle is still holding the old request
  assign req_s = {is_active(pl_cmd) & ~pl_ack_q, is_active(ps_cmd) & ~ps_ack_q};

  rr_arbiter2 u_rr (
    .req_i     (req_s),
    .last_pl_i (last_pl_q),
    .gnt_o     (gnt_s)
  );

  assign win_cmd_s = gnt_s[1] ? pl_cmd : ps_cmd;

  // Next-state and registered-output logic for the access FSM
  always_comb begin
    state_d     = state_q;
    last_pl_d   = last_pl_q;
    wr_d        = wr_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_pl_d  = grant_pl_q;
    ps_ack_d    = 1'b0;
    pl_ack_d    = 1'b0;
    ps_rdata_d  = ps_rdata_q;
    pl_rdata_d  = pl_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          grant_pl_d  = gnt_s[1];
          last_pl_d   = gnt_s[1];
          wr_d        = (win_cmd_s == CMD_WRITE);
          mem_en_d    = 1'b1;
          mem_we_d    = (win_cmd_s == CMD_WRITE);
          mem_addr_d  = gnt_s[1] ? pl_addr : ps_addr;
          mem_wdata_d = gnt_s[1] ? pl_wdata : ps_wdata;
          state_d     = ACCESS;
        end else begin
          state_d     = IDLE;
        end
      end
      ACCESS: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        if (grant_pl_q) begin
          pl_ack_d = 1'b1;
          if (!wr_q) pl_rdata_d = mem_rdata;
        end else begin
          ps_ack_d = 1'b1;
          if (!wr_q) ps_rdata_d = mem_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_pl_q   <= 1'b0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_pl_q  <= 1'b0;
      ps_ack_q    <= 1'b0;
      pl_ack_q    <= 1'b0;
      ps_rdata_q  <= '0;
      pl_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_pl_q   <= last_pl_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_pl_q  <= grant_pl_d;
      ps_ack_q    <= ps_ack_d;
      pl_ack_q    <= pl_ack_d;
      ps_rdata_q  <= ps_rdata_d;
      pl_rdata_q  <= pl_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_pl  = grant_pl_q;
  assign ps_ack    = ps_ack_q;
  assign pl_ack    = pl_ack_q;
  assign ps_rdata  = ps_rdata_q;
  assign pl_rdata  = pl_rdata_q;
  assign busy      = (state_q == ACCESS) || (state_q == RESP);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner
// sequences, and a randomized run against a transaction-level schedule model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ps_cmd, pl_cmd;
  logic [7:0]  ps_addr, pl_addr;
  logic [31:0] ps_wdata, pl_wdata, ps_rdata, pl_rdata;
  logic        ps_ack, pl_ack;
  logic        mem_en, mem_we, grant_pl, busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        bk_we = 1'b0;
  logic [7:0]  bk_addr = 8'd0;
  logic [31:0] bk_data = 32'd0;
  logic [31:0] mem_arr [256];

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ps_rd, exp_pl_rd;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ps_cmd(ps_cmd), .ps_addr(ps_addr), .ps_wdata(ps_wdata),
    .ps_rdata(ps_rdata), .ps_ack(ps_ack),
    .pl_cmd(pl_cmd), .pl_addr(pl_addr), .pl_wdata(pl_wdata),
    .pl_rdata(pl_rdata), .pl_ack(pl_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant_pl(grant_pl), .busy(busy)
  );

  // Block RAM model with a backdoor write port for preloading
  always @(posedge clk) begin
    if (bk_we) mem_arr[bk_addr] <= bk_data;
    else if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    ps_cmd = CMD_IDLE; ps_addr = 8'd0; ps_wdata = 32'd0;
    pl_cmd = CMD_IDLE; pl_addr = 8'd0; pl_wdata = 32'd0;
  endtask

  task automatic bk(input logic [7:0] a, input logic [31:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    next_cycle();
    bk_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_ports();
    exp_ps_rd = 32'd0;
    exp_pl_rd = 32'd0;
    repeat (2) next_cycle();
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_acks", {ps_ack, pl_ack}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_pl, 1'b0);
    chk("rst_rdata", {ps_rdata, pl_rdata}, 64'd0);
    rst = 1'b1;
    next_cycle();
  endtask

  // One isolated access: request at T, memory port in T+1, ack in T+3
  task automatic do_single(input bit pl, input logic [2:0] cmd, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
    idle_ports();
    if (pl) begin pl_cmd = cmd; pl_addr = a; pl_wdata = wd; end
    else    begin ps_cmd = cmd; ps_addr = a; ps_wdata = wd; end
    next_cycle();
    chk("acc_en", mem_en, 1'b1);
    chk("acc_we", mem_we, cmd == CMD_WRITE);
    chk("acc_addr", mem_addr, a);
    if (cmd == CMD_WRITE) chk("acc_wdata", mem_wdata, wd);
    chk("acc_grant", grant_pl, pl);
    chk("acc_busy", busy, 1'b1);
    next_cycle();
    chk("resp_en", mem_en, 1'b0);
    chk("resp_busy", busy, 1'b1);
    chk("resp_noack", {ps_ack, pl_ack}, 2'b00);
    next_cycle();
    if (cmd == CMD_READ) begin
      if (pl) exp_pl_rd = exp_rd; else exp_ps_rd = exp_rd;
    end
    chk("ack_ps", ps_ack, !pl);
    chk("ack_pl", pl_ack, pl);
    chk("ack_ps_rdata", ps_rdata, exp_ps_rd);
    chk("ack_pl_rdata", pl_rdata, exp_pl_rd);
    chk("ack_busy", busy, 1'b0);
    next_cycle();
    idle_ports();
    chk("ack_pulse", {ps_ack, pl_ack}, 2'b00);
    next_cycle();
  endtask

  typedef struct {
    bit          pl;
    logic [2:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  // Random-phase reference state
  logic [31:0] ref_mem [16];
  int          exp_ack_c [2];
  bit          pend_rd [2];
  logic [31:0] pend_data [2];
  logic [31:0] exp_rd_m [2];
  logic [2:0]  a_cmd [2];
  logic [7:0]  a_addr [2];
  logic [31:0] a_wd [2];
  bit          ack_prev [2];
  bit          ack_obs [2];
  int          next_dec, g_cyc, win;
  bit          last_pl, g_pl, g_we, exp_gp;
  logic [7:0]  g_addr;
  logic [31:0] g_wdata;

  initial begin
    logic [2:0] illegal [4];
    illegal[0] = 3'd0; illegal[1] = 3'd1; illegal[2] = 3'd4; illegal[3] = 3'd7;

    vecs[0] = '{1'b1, CMD_WRITE, 8'd7,   32'h1234_5678, 32'h0};
    vecs[1] = '{1'b0, CMD_READ,  8'd255, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, CMD_READ,  8'd7,   32'h0,         32'h1234_5678};
    vecs[3] = '{1'b0, CMD_WRITE, 8'd255, 32'h0A0B_0C0D, 32'h0};
    vecs[4] = '{1'b1, CMD_READ,  8'd255, 32'h0,         32'h0A0B_0C0D};
    vecs[5] = '{1'b0, CMD_READ,  8'd7,   32'h0,         32'h1234_5678};
    vecs[6] = '{1'b0, CMD_WRITE, 8'd0,   32'hFFFF_FFFF, 32'h0};
    vecs[7] = '{1'b0, CMD_READ,  8'd0,   32'h0,         32'hFFFF_FFFF};

    do_reset();
    bk(8'd255, 32'hDEAD_BEEF);
    bk(8'd7, 32'h0);
    bk(8'd0, 32'h0);
    for (int i = 0; i < 8; i++)
      do_single(vecs[i].pl, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // Tie right after reset: PL first, PS granted when the PL ack shows
    do_reset();
    bk(8'd3, 32'hCAFE_0003);
    ps_cmd = CMD_READ;  ps_addr = 8'd3;
    pl_cmd = CMD_WRITE; pl_addr = 8'd5; pl_wdata = 32'h7777_0005;
    next_cycle();
    chk("tie_grant_pl", grant_pl, 1'b1);
    chk("tie_addr_pl", mem_addr, 8'd5);
    next_cycle();
    next_cycle();
    chk("tie_pl_ack", {ps_ack, pl_ack}, 2'b01);
    next_cycle();
    pl_cmd = CMD_IDLE;
    chk("tie_grant_ps", grant_pl, 1'b0);
    chk("tie_en_ps", {mem_en, mem_we}, 2'b10);
    chk("tie_addr_ps", mem_addr, 8'd3);
    next_cycle();
    chk("tie_mid", {ps_ack, pl_ack}, 2'b00);
    next_cycle();
    chk("tie_ps_ack", {ps_ack, pl_ack}, 2'b10);
    chk("tie_ps_rdata", ps_rdata, 32'hCAFE_0003);
    chk("tie_pl_rdata", pl_rdata, 32'h0);
    next_cycle();
    idle_ports();

    // Both ports held for 12 accesses: strict PL/PS alternation
    do_reset();
    ps_cmd = CMD_READ;  ps_addr = 8'd1;
    pl_cmd = CMD_WRITE; pl_addr = 8'd2; pl_wdata = 32'h0000_0022;
    for (int i = 1; i <= 36; i++) begin
      next_cycle();
      chk("alt_pl_ack", pl_ack, (i % 3 == 0) && ((i / 3) % 2 == 1));
      chk("alt_ps_ack", ps_ack, (i % 3 == 0) && ((i / 3) % 2 == 0));
      if (i % 3 == 1) chk("alt_grant", grant_pl, ((i / 3) % 2 == 0));
    end
    idle_ports();

    // Non-request codes never start an access
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 5; j++) begin
        ps_cmd = illegal[k]; pl_cmd = illegal[k];
        ps_addr = 8'($urandom); pl_addr = 8'($urandom);
        next_cycle();
        chk("ill_en", mem_en, 1'b0);
        chk("ill_ack", {ps_ack, pl_ack}, 2'b00);
        chk("ill_busy", busy, 1'b0);
      end
    end
    idle_ports();

    // Reset during the ACCESS cycle of a PL write
    do_reset();
    bk(8'd9, 32'h1111_1111);
    pl_cmd = CMD_WRITE; pl_addr = 8'd9; pl_wdata = 32'h5555_AAAA;
    next_cycle();
    chk("mid_en_before", mem_en, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_en_drop", {mem_en, mem_we}, 2'b00);
    chk("mid_busy", busy, 1'b0);
    pl_cmd = CMD_IDLE;
    for (int j = 0; j < 2; j++) begin
      next_cycle();
      chk("mid_no_ack", pl_ack, 1'b0);
    end
    chk("mid_write_lost", mem_arr[9], 32'h1111_1111);
    rst = 1'b1;
    next_cycle();
    chk("mid_post_idle", {mem_en, busy, ps_ack, pl_ack, grant_pl}, 5'd0);
    chk("mid_post_rdata", {ps_rdata, pl_rdata}, 64'd0);
    do_single(1'b1, CMD_WRITE, 8'd9, 32'h5555_AAAA, 32'h0);
    do_single(1'b1, CMD_READ, 8'd9, 32'h0, 32'h5555_AAAA);

    // Randomized traffic against the service-schedule model
    do_reset();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      bk(8'(a), ref_mem[a]);
    end
    for (int p = 0; p < 2; p++) begin
      exp_ack_c[p] = -10; pend_rd[p] = 1'b0; pend_data[p] = 32'd0;
      exp_rd_m[p] = 32'd0; a_cmd[p] = CMD_IDLE; a_addr[p] = 8'd0;
      a_wd[p] = 32'd0; ack_prev[p] = 1'b0;
    end
    next_dec = 0; g_cyc = -10; last_pl = 1'b0; exp_gp = 1'b0;
    g_pl = 1'b0; g_we = 1'b0; g_addr = 8'd0; g_wdata = 32'd0;
    for (int c = 0; c < 800; c++) begin
      ack_obs[0] = ps_ack; ack_obs[1] = pl_ack;
      for (int p = 0; p < 2; p++)
        if (exp_ack_c[p] == c && pend_rd[p]) exp_rd_m[p] = pend_data[p];
      if (c == g_cyc + 1) exp_gp = g_pl;
      chk("rnd_ps_ack", ps_ack, exp_ack_c[0] == c);
      chk("rnd_pl_ack", pl_ack, exp_ack_c[1] == c);
      chk("rnd_ps_rdata", ps_rdata, exp_rd_m[0]);
      chk("rnd_pl_rdata", pl_rdata, exp_rd_m[1]);
      chk("rnd_en", mem_en, c == g_cyc + 1);
      chk("rnd_we", mem_we, (c == g_cyc + 1) && g_we);
      chk("rnd_busy", busy, (c == g_cyc + 1) || (c == g_cyc + 2));
      chk("rnd_grant", grant_pl, exp_gp);
      if (c == g_cyc + 1) begin
        chk("rnd_addr", mem_addr, g_addr);
        if (g_we) chk("rnd_wdata", mem_wdata, g_wdata);
      end
      for (int p = 0; p < 2; p++) begin
        if (!is_active(a_cmd[p]) || ack_prev[p]) begin
          case ($urandom_range(0, 3))
            0: a_cmd[p] = CMD_READ;
            1: a_cmd[p] = CMD_WRITE;
            2: a_cmd[p] = 3'($urandom_range(4, 7));
            default: a_cmd[p] = 3'($urandom_range(0, 1));
          endcase
          a_addr[p] = 8'($urandom_range(0, 15));
          a_wd[p]   = $urandom;
        end
        ack_prev[p] = ack_obs[p];
      end
      ps_cmd = a_cmd[0]; ps_addr = a_addr[0]; ps_wdata = a_wd[0];
      pl_cmd = a_cmd[1]; pl_addr = a_addr[1]; pl_wdata = a_wd[1];
      if (c >= next_dec) begin
        bit e0, e1;
        e0 = is_active(a_cmd[0]) && (exp_ack_c[0] != c);
        e1 = is_active(a_cmd[1]) && (exp_ack_c[1] != c);
        win = -1;
        if (e0 && e1) win = last_pl ? 0 : 1;
        else if (e1)  win = 1;
        else if (e0)  win = 0;
        if (win >= 0) begin
          last_pl = (win == 1);
          g_cyc = c; g_pl = (win == 1);
          g_we = (a_cmd[win] == CMD_WRITE);
          g_addr = a_addr[win]; g_wdata = a_wd[win];
          pend_rd[win] = !g_we;
          if (g_we) ref_mem[g_addr[3:0]] = g_wdata;
          else      pend_data[win] = ref_mem[g_addr[3:0]];
          exp_ack_c[win] = c + 3;
          next_dec = c + 3;
        end
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single-port result/operand memory shared by the PS bridge and the PL matrix calculator. It accepts `cmd`/address/data requests from both sides, grants them round-robin, drives the memory port with registered signals, and returns read data plus a one-cycle acknowledge to the served requester. It sits between the calculator, the PS-side register bridge and the block RAM.

## Interface
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 32: memory data width.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ps_cmd`  in  3  PS command: 3'd2 write, 3'd3 read; any other code is idle.
- `ps_addr`  in  ADDR_W  PS address.
- `ps_wdata`  in  DATA_W  PS write data.
- `ps_rdata`  out  DATA_W  last PS read result.
- `ps_ack`  out  1  one-cycle completion pulse for the PS.
- `pl_cmd`, `pl_addr`, `pl_wdata`  in  3/ADDR_W/DATA_W  calculator request, same encoding as the PS side.
- `pl_rdata`  out  DATA_W  last PL read result.
- `pl_ack`  out  1  one-cycle completion pulse for the PL.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after the enabled read.
- `grant_pl`  out  1  1 while the current access belongs to the PL.
- `busy`  out  1  1 in states ACCESS and RESP.

## Operation
- A request is active while `cmd` is 2 or 3. The requester holds `cmd`/addr/data stable until it sees its ack, then drops or changes `cmd` in the next cycle.
- In the cycle a port's ack is high, that port's request is masked. A held request in the following cycle counts as a new access.
- FSM:
  - IDLE: sample the unmasked requests. If any is active, pick a winner, register the `mem_*` signals and `grant_pl`, and go to ACCESS.
  - ACCESS: the memory sees the access. Go to RESP and clear `mem_en`/`mem_we`.
  - RESP: for a read, register `mem_rdata` into the winner's rdata. For both reads and writes, pulse the winner's ack. Return to IDLE.
- Arbitration: one-bit last-served pointer. If only one port requests, it wins. If both request, the port not served last wins. After reset the pointer is "PS", so the PL wins the first tie. The pointer updates when the grant is made.
- Writes take the same path as reads, so latency is uniform.
- rdata outputs hold their value until the next read completes for that port. The other port's rdata never changes.

## Timing
- Request first seen in IDLE at cycle T: `mem_en` (and `mem_we` for a write) high during T+1. A read's `mem_rdata` is sampled at the end of T+2. Ack and new rdata are visible in T+3.
- Minimum latency is 3 cycles from request to ack.
- Back-to-back accesses:
  - The other port's waiting request is granted in T+3 (IDLE), so its ack comes in T+6.
  - The same port's next request, presented in T+4, gets its ack in T+7.
- Reset values, applied asynchronously: all outputs 0, state IDLE, pointer PS.
- Reset asserted mid-operation clears `mem_en`/`mem_we` immediately. The pending access is abandoned with no ack; any write not yet captured by the memory is lost.
- Both ports presenting the same address at once: served serially in arbitration order, with no merging.

## Structure
- Package `mem_arb_pkg`:
  - command constants CMD_WRITE=3'd2, CMD_READ=3'd3, CMD_IDLE=3'd4;
  - the state enum IDLE/ACCESS/RESP;
  - a `is_active(cmd)` function.
- Sub-module `rr_arbiter2`: combinational two-way round-robin pick from the request vector plus the pointer, outputting a one-hot grant. The pointer register lives in the parent.

## Test plan
- Reset, then PL write addr 8'd7, data 32'h1234_5678 at T → `mem_en`=`mem_we`=1 with addr 7 in T+1; `pl_ack` in T+3; `ps_ack` never high.
- PS read addr 8'd255, memory model returns 32'hDEAD_BEEF → `ps_rdata`=32'hDEAD_BEEF with `ps_ack` in T+3; `pl_rdata` still 0.
- Both ports request in the same cycle right after reset → PL acked in T+3, PS granted in T+3, PS acked in T+6; `grant_pl` reads 1 then 0.
- Both ports hold requests continuously for 12 accesses → grants strictly alternate PL, PS, PL…; each ack lasts exactly one cycle.
- `cmd` values 0, 1, 4, 7 on both ports for 20 cycles → `mem_en` stays 0; no ack; `busy`=0.
- `rst` asserted during ACCESS of a PL write → `mem_en` drops in the same cycle; no `pl_ack`; after release, state IDLE and outputs 0; a re-issued request completes normally.
